// File: rtl/io_pkg.sv
// Shared constants for the debounced switch/key register port: input widths,
// register map and counter width.
package io_pkg;

  localparam int SW_W   = 10;
  localparam int KEY_W  = 2;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ADDR_SW   = 2'd0,
    ADDR_KEY  = 2'd1,
    ADDR_FLAG = 2'd2,
    ADDR_CNT  = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/debounce_bit.sv
// One raw input: 2-flop synchronizer, then a level is accepted only after it
// has differed from the current stable level for DEBOUNCE_CYCLES cycles.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
      stable  <= RESET_VAL;
      count   <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // any return to the stable level restarts the qualification window
      if (sync_p1 == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= sync_p1;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_debounce_port.sv
// Debounced slide switches and push buttons behind a small CPU register port
// with sticky press flags, wrapping press counters and a level interrupt.
module input_debounce_port
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              irq
);

  logic [SW_W-1:0]             sw_state;
  logic [KEY_W-1:0]            key_stable;
  logic [KEY_W-1:0]            key_state;
  logic [KEY_W-1:0]            key_prev;
  logic [KEY_W-1:0]            press;
  logic [KEY_W-1:0]            press_flag;
  logic [KEY_W-1:0][CNT_W-1:0] press_cnt;
  logic [DATA_W-1:0]           rd_mux;
  reg_addr_e                   sel;
  logic                        wr_flag;
  logic                        wr_cnt;
  logic                        unused_wdata;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_in[i]),
      .stable(sw_state[i])
    );
  end

  // keys idle high, so their synchronizers and stable level reset to released
  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (key_in[i]),
      .stable(key_stable[i])
    );
  end

  assign key_state    = ~key_stable;
  assign press        = key_state & ~key_prev;
  assign sel          = reg_addr_e'(addr);
  assign wr_flag      = wr_en && (sel == ADDR_FLAG);
  assign wr_cnt       = wr_en && (sel == ADDR_CNT);
  assign irq          = |press_flag;
  assign unused_wdata = ^wdata[DATA_W-1:KEY_W];

  always_comb begin
    rd_mux = '0;
    case (sel)
      ADDR_SW:   rd_mux = {{(DATA_W-SW_W){1'b0}}, sw_state};
      ADDR_KEY:  rd_mux = {{(DATA_W-KEY_W){1'b0}}, key_state};
      ADDR_FLAG: rd_mux = {{(DATA_W-KEY_W){1'b0}}, press_flag};
      ADDR_CNT:  rd_mux = {16'b0, press_cnt[1], press_cnt[0]};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev   <= '0;
      press_flag <= '0;
      press_cnt  <= '0;
      rdata      <= '0;
      rd_valid   <= 1'b0;
    end else begin
      key_prev <= key_state;
      rd_valid <= rd_en;
      if (rd_en) rdata <= rd_mux;
      // a press landing on the same edge as a clear always survives it
      for (int i = 0; i < KEY_W; i++) begin
        if (press[i]) begin
          press_flag[i] <= 1'b1;
        end else if (wr_flag && wdata[i]) begin
          press_flag[i] <= 1'b0;
        end
        if (wr_cnt) begin
          press_cnt[i] <= press[i] ? CNT_W'(1) : '0;
        end else if (press[i]) begin
          press_cnt[i] <= press_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/input_debounce_port.md
INPUT_DEBOUNCE_PORT -- requirements
Module: input_debounce_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required before a level is accepted (10 ms at 50 MHz; benches use 4).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sw_in  input  10  raw slide switches, asynchronous, active-high.
REQ-005 SHALL have port key_in  input  2  raw push buttons, asynchronous, active-low (pressed = 0).
REQ-006 SHALL have port rd_en  input  1  CPU read strobe, one cycle.
REQ-007 SHALL have port wr_en  input  1  CPU write strobe, one cycle.
REQ-008 SHALL have port addr  input  2  register select.
REQ-009 SHALL have port wdata  input  32  CPU write data.
REQ-010 SHALL have port rdata  output  32  registered read data.
REQ-011 SHALL have port rd_valid  output  1  high exactly one cycle after an accepted rd_en.
REQ-012 SHALL have port irq  output  1  high while any key press flag is set.

Function
REQ-013 SHALL pass each of the 12 raw inputs through a 2-flop synchronizer before any other use.
REQ-014 SHALL per input keep a stable level and counter: counter increments while synchronized value != stable, clears to 0 when equal.
REQ-015 SHALL, when counter equals DEBOUNCE_CYCLES-1 and value still differs, update stable to synchronized value and clear counter on that edge.
REQ-016 SHALL give a clean input change a latency of DEBOUNCE_CYCLES+2 cycles from first sampling edge to stable output; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-017 SHALL present key stable state inverted: key_state[i]=1 means pressed.
REQ-018 SHALL detect a press as key_state[i] rising 0->1 (one-cycle pulse); release is not an event.
REQ-019 SHALL on each press set sticky flag press_flag[i] and increment 8-bit press_cnt[i], wrapping 255->0.
REQ-020 SHALL map reads: addr 0 = {22'b0, sw_state[9:0]}; 1 = {30'b0, key_state[1:0]}; 2 = {30'b0, press_flag[1:0]}; 3 = {16'b0, press_cnt[1], press_cnt[0]}.
REQ-021 SHALL register rdata on the rd_en edge; rdata holds its value until the next read.
REQ-022 SHALL on write to addr 2 clear press_flag[i] where wdata[i]=1 (W1C); other bits unchanged.
REQ-023 SHALL on write to addr 3 clear both press counters regardless of wdata.
REQ-024 SHALL ignore writes to addr 0 and 1.
REQ-025 SHALL, when a press and its W1C clear coincide, leave the flag set (set wins).
REQ-026 SHALL, when a press and a counter clear coincide, leave that counter at 1.
REQ-027 SHALL, when rd_en and wr_en coincide, perform both; read returns pre-write value.
REQ-028 SHALL drive irq = |press_flag, combinationally from flag flops.

Reset
REQ-029 SHALL on rst asynchronously set sw synchronizers/stable to 0, key synchronizers to 1 (released), key stable to released, all counters 0.
REQ-030 SHALL on rst clear press_flag, press_cnt, rdata, rd_valid, irq to 0.
REQ-031 SHALL generate no press event on reset release even if a key is held; a held key is reported after DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-032 SHALL place register address constants (ADDR_SW, ADDR_KEY, ADDR_FLAG, ADDR_CNT) and the 10/2 input widths in shared package io_pkg.
REQ-033 SHALL instantiate sub-module debounce_bit (synchronizer + counter + stable flop, parameter DEBOUNCE_CYCLES) once per input, 12 instances.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 SHALL check reset: assert rst mid-count with key0 pressed -> rdata=0, rd_valid=0, irq=0, all registers read 0 after release.
REQ-035 SHALL check latency: sw_in=10'h2A5 held -> addr 0 reads 0x000 at cycle 5, 0x2A5 from cycle 6.
REQ-036 SHALL check bounce: key_in[0] toggles with 2-cycle pulses 3 times then holds 0 -> exactly one press, addr 2 = 0x1, addr 3 = 0x0001, irq=1.
REQ-037 SHALL check W1C: flags=0x3, write addr 2 wdata=0x1 -> flags=0x2, irq=1; press key0 on clearing cycle -> flag0 stays 1.
REQ-038 SHALL check wrap: 256 clean presses of key1 -> addr 3 = 0x0000; write addr 3 coincident with a press -> counter 1.
